// File: rtl/bg_tile_fetch.sv
// Background tile fetcher: walks NTILES tiles from a loopy v, reading NT/AT/pattern bytes
// over the 14-bit PPU bus and handing each finished tile to a single-entry valid/ready register.
module bg_tile_fetch #(
  parameter int NTILES = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [14:0] v_i,
  input  logic        bg_pt,
  output logic [13:0] addr,
  output logic        rw,
  input  logic [7:0]  data_i,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [7:0]  tile_lo,
  output logic [7:0]  tile_hi,
  output logic [1:0]  tile_pal,
  output logic [14:0] v_o,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(NTILES + 1);

  typedef enum logic [3:0] {
    IDLE, NT0, NT1, AT0, AT1, PL0, PL1, PH0, PH1, WAIT
  } state_t;

  state_t          state, state_nx;
  logic            pt;
  logic [CW-1:0]   count;
  logic [7:0]      nt_byte, at_byte, lo_byte, hi_byte;
  logic            load;
  logic            free, accept, last_tile, final_wait;
  logic [14:0]     v_inc;
  logic [13:0]     at_addr, pl_addr, ph_addr;
  logic [2:0]      pal_sh;
  logic [7:0]      at_sh;
  logic [7:0]      hi_src;

  assign rw         = 1'b1;
  assign busy       = (state != IDLE);
  assign free       = !tile_valid || tile_ready;
  assign accept     = tile_valid && tile_ready;
  assign last_tile  = (count == CW'(NTILES - 1));
  assign final_wait = (count == CW'(NTILES));
  assign done       = (state == WAIT) && final_wait && accept;

  // Coarse X step: wrap into the horizontally adjacent nametable.
  always_comb begin
    v_inc = v_o;
    if (v_o[4:0] == 5'd31) begin
      v_inc[4:0] = 5'd0;
      v_inc[10]  = ~v_o[10];
    end else begin
      v_inc[4:0] = v_o[4:0] + 5'd1;
    end
  end

  assign at_addr = 14'h23C0 | {2'b00, v_o[11:10], 10'b0} | {8'b0, v_o[9:7], 3'b0}
                 | {11'b0, v_o[4:2]};
  assign pl_addr = {1'b0, pt, nt_byte, 1'b0, v_o[14:12]};
  assign ph_addr = {1'b0, pt, nt_byte, 1'b1, v_o[14:12]};
  assign pal_sh  = {v_o[6], v_o[1], 1'b0};
  assign at_sh   = at_byte >> pal_sh;
  // The high plane arrives on the bus in PH1; from WAIT it comes from the holding byte.
  assign hi_src  = (state == PH1) ? data_i : hi_byte;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = NT0;
      NT0:  state_nx = NT1;
      NT1:  state_nx = AT0;
      AT0:  state_nx = AT1;
      AT1:  state_nx = PL0;
      PL0:  state_nx = PL1;
      PL1:  state_nx = PH0;
      PH0:  state_nx = PH1;
      PH1: begin
        if (free) begin
          load     = 1'b1;
          state_nx = last_tile ? WAIT : NT0;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (final_wait) begin
          if (accept) state_nx = IDLE;
        end else if (free) begin
          load     = 1'b1;
          state_nx = last_tile ? WAIT : NT0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      tile_valid <= 1'b0;
      tile_lo    <= '0;
      tile_hi    <= '0;
      tile_pal   <= '0;
      v_o        <= '0;
      pt         <= 1'b0;
      count      <= '0;
      nt_byte    <= '0;
      at_byte    <= '0;
      lo_byte    <= '0;
      hi_byte    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          v_o   <= v_i;
          pt    <= bg_pt;
          count <= '0;
          addr  <= {2'b10, v_i[11:0]};
        end
        NT1: begin
          nt_byte <= data_i;
          addr    <= at_addr;
        end
        AT1: begin
          at_byte <= data_i;
          addr    <= pl_addr;
        end
        PL1: begin
          lo_byte <= data_i;
          addr    <= ph_addr;
        end
        PH1: hi_byte <= data_i;
        default: ;
      endcase

      // Loading wins over acceptance so a same-cycle accept+load leaves valid high.
      if (load) begin
        tile_valid <= 1'b1;
        tile_lo    <= lo_byte;
        tile_hi    <= hi_src;
        tile_pal   <= at_sh[1:0];
        v_o        <= v_inc;
        count      <= count + CW'(1);
        if (state_nx == NT0) addr <= {2'b10, v_inc[11:0]};
      end else if (accept) begin
        tile_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bg_tile_fetch.sv
// Bench for bg_tile_fetch: random memory and backpressure, scoreboard of the bus address
// sequence and tile stream computed from the address/palette rules, plus literal pins.
module tb_bg_tile_fetch;
  localparam int N = 34;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, bg_pt = 1'b0, tile_ready = 1'b0;
  logic [14:0] v_i = '0;
  logic [7:0]  data_i;
  logic [13:0] addr;
  logic        rw, tile_valid, busy, done;
  logic [7:0]  tile_lo, tile_hi;
  logic [1:0]  tile_pal;
  logic [14:0] v_o;

  bg_tile_fetch #(.NTILES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .v_i(v_i), .bg_pt(bg_pt),
    .addr(addr), .rw(rw), .data_i(data_i), .tile_valid(tile_valid),
    .tile_ready(tile_ready), .tile_lo(tile_lo), .tile_hi(tile_hi),
    .tile_pal(tile_pal), .v_o(v_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:16383];
  always @(posedge clk) data_i <= mem[addr];

  typedef struct { logic [7:0] lo; logic [7:0] hi; logic [1:0] pal; } tile_t;
  tile_t       exp_tiles[$];
  logic [13:0] exp_addrs[$];
  logic [13:0] obs_addr[$];
  int          obs_cyc[$];
  logic [14:0] final_v;
  logic [13:0] exp_ph1;
  int          n_cmp = 0, n_err = 0, cyc = 0, ready_pct = 100, done_cnt = 0;
  bit          active = 0, done_seen = 0, hold_ready = 0, got_first = 0;
  logic [1:0]  first_pal;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++; n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: what each tile must fetch and deliver, from plain arithmetic on v.
  task automatic build(input logic [14:0] v0, input logic pt);
    int vi, nt, at, pl, sh, ntb, atb;
    tile_t t;
    vi = int'(v0);
    for (int i = 0; i < N; i++) begin
      nt  = 'h2000 + vi % 4096;
      at  = 'h23C0 + ((vi >> 10) % 4) * 1024 + ((vi >> 7) % 8) * 8 + (vi >> 2) % 8;
      ntb = int'(mem[nt]);
      atb = int'(mem[at]);
      pl  = int'(pt) * 4096 + ntb * 16 + (vi >> 12) % 8;
      sh  = ((vi >> 6) % 2) * 4 + ((vi >> 1) % 2) * 2;
      exp_addrs.push_back(14'(nt));
      exp_addrs.push_back(14'(at));
      exp_addrs.push_back(14'(pl));
      exp_addrs.push_back(14'(pl + 8));
      if (i == 1) exp_ph1 = 14'(pl + 8);
      t.lo = mem[pl]; t.hi = mem[pl + 8]; t.pal = 2'((atb >> sh) % 4);
      exp_tiles.push_back(t);
      if (vi % 32 == 31) vi = (vi - 31) ^ 1024;
      else               vi = vi + 1;
    end
    final_v = 15'(vi);
  endtask

  initial forever begin
    @(posedge clk); #1;
    tile_ready = hold_ready ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
  end

  // Per-cycle compare against the scoreboard.
  initial begin
    logic [13:0] last_addr;
    logic [17:0] prev_tile;
    bit prev_hold, acc, lastacc;
    tile_t t;
    last_addr = '0; prev_hold = 0; prev_tile = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        last_addr = addr; prev_hold = 0;
      end else begin
        if (addr !== last_addr) begin
          obs_addr.push_back(addr); obs_cyc.push_back(cyc);
          if (exp_addrs.size() == 0) flag("addr_extra");
          else chk("addr", 32'(addr), 32'(exp_addrs.pop_front()));
          last_addr = addr;
        end
        if (prev_hold) begin
          chk("hold_valid", 32'(tile_valid), 32'd1);
          chk("hold_tile", 32'({tile_lo, tile_hi, tile_pal}), 32'(prev_tile));
        end
        prev_hold = tile_valid && !tile_ready;
        prev_tile = {tile_lo, tile_hi, tile_pal};
        acc = tile_valid && tile_ready;
        lastacc = 0;
        if (acc) begin
          if (exp_tiles.size() == 0) flag("tile_extra");
          else begin
            t = exp_tiles.pop_front();
            chk("tile_lo", 32'(tile_lo), 32'(t.lo));
            chk("tile_hi", 32'(tile_hi), 32'(t.hi));
            chk("tile_pal", 32'(tile_pal), 32'(t.pal));
            lastacc = (exp_tiles.size() == 0);
            if (!got_first) begin first_pal = tile_pal; got_first = 1; end
          end
        end
        if (active) chk("done", 32'(done), 32'(lastacc));
        if (done) begin done_cnt++; done_seen = 1; end
      end
    end
  end

  task automatic launch(input logic [14:0] v, input logic pt);
    exp_addrs.delete(); exp_tiles.delete(); obs_addr.delete(); obs_cyc.delete();
    build(v, pt);
    done_cnt = 0; done_seen = 0; got_first = 0;
    @(posedge clk); #1;
    v_i = v; bg_pt = pt; start = 1'b1; active = 1;
    @(posedge clk); #1;
    start = 1'b0; v_i = 15'($urandom); bg_pt = 1'($urandom);
  endtask

  task automatic finish_wait(input string nm);
    int k;
    k = 0;
    while (!done_seen && k < 3000) begin @(posedge clk); k++; end
    if (!done_seen) flag({nm, "_timeout"});
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({nm, "_busy_end"}, 32'(busy), 32'd0);
    chk({nm, "_v_o"}, 32'(v_o), 32'(final_v));
    chk({nm, "_tiles_left"}, 32'(exp_tiles.size()), 32'd0);
    chk({nm, "_addrs_left"}, 32'(exp_addrs.size()), 32'd0);
    active = 0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_addr"}, 32'(addr), 32'd0);
    chk({nm, "_rw"}, 32'(rw), 32'd1);
    chk({nm, "_valid"}, 32'(tile_valid), 32'd0);
    chk({nm, "_lohi"}, 32'({tile_lo, tile_hi}), 32'd0);
    chk({nm, "_pal"}, 32'(tile_pal), 32'd0);
    chk({nm, "_v_o"}, 32'(v_o), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    #2 rst = 1'b0;
    #1 chk_reset("por");
    #20 rst = 1'b1;

    // Tile 0 at v=0: fixed addresses, two cycles each, valid 8 cycles after start.
    mem[14'h2000] = 8'h24;
    ready_pct = 100;
    launch(15'h0000, 1'b0);
    k = 0;
    while (!tile_valid && k < 50) begin @(posedge clk); #1; k++; end
    chk("first_latency", 32'(k), 32'd8);
    finish_wait("t1");
    chk("t1_a0", 32'(obs_addr[0]), 32'h2000);
    chk("t1_a1", 32'(obs_addr[1]), 32'h23C0);
    chk("t1_a2", 32'(obs_addr[2]), 32'h0240);
    chk("t1_a3", 32'(obs_addr[3]), 32'h0248);
    for (int i = 0; i < 4; i++) chk("t1_hold2", 32'(obs_cyc[i+1] - obs_cyc[i]), 32'd2);

    // Coarse X wrap into the next nametable.
    ready_pct = 50;
    launch(15'h001F, 1'b0);
    finish_wait("t2");
    chk("t2_nt0", 32'(obs_addr[0]), 32'h201F);
    chk("t2_at0", 32'(obs_addr[1]), 32'h23C7);
    chk("t2_nt1", 32'(obs_addr[4]), 32'h2400);
    chk("t2_at1", 32'(obs_addr[5]), 32'h27C0);
    chk("t2_vfinal", 32'(v_o), 32'h0001);

    // Pattern table select and fine Y in the pattern address.
    mem[14'h2000] = 8'h10;
    launch(15'h5000, 1'b1);
    finish_wait("t3");
    chk("t3_pl", 32'(obs_addr[2]), 32'h1105);
    chk("t3_ph", 32'(obs_addr[3]), 32'h110D);

    // Palette quadrant selection.
    mem[14'h23C0] = 8'b11_10_01_00;
    launch(15'h0002, 1'b0);
    finish_wait("t4");
    chk("t4_pal", 32'(first_pal), 32'b01);

    // Long stall: tile 0 held, fetcher parks after tile 1.
    hold_ready = 1;
    launch(15'($urandom), 1'($urandom));
    repeat (20) @(posedge clk);
    #1;
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_valid", 32'(tile_valid), 32'd1);
    chk("stall_addr", 32'(addr), 32'(exp_ph1));
    chk("stall_nfetch", 32'(obs_addr.size()), 32'd8);
    hold_ready = 0; ready_pct = 100;
    finish_wait("t5");

    // Asynchronous reset in the middle of AT1, then a clean restart.
    launch(15'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    active = 0;
    #2 rst = 1'b0;
    #1 chk_reset("midrst");
    exp_addrs.delete(); exp_tiles.delete();
    #5 rst = 1'b1;
    #1 chk("midrst_idle", 32'(busy), 32'd0);
    ready_pct = 70;
    launch(15'($urandom), 1'($urandom));
    finish_wait("t6");

    for (int r = 0; r < 8; r++) begin
      ready_pct = (r % 3 == 0) ? 100 : (r % 3 == 1) ? 60 : 25;
      launch(15'($urandom), 1'($urandom));
      finish_wait("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
